// File: rtl/io_port_pkg.sv
// io_port_pkg: shared defaults and the RX holding-register state encoding
// for the io_port block.
package io_port_pkg;

    localparam int IO_WIDTH = 8;
    localparam int IO_DEPTH = 4;

    typedef enum logic [0:0] {
        R_EMPTY = 1'b0,
        R_FULL  = 1'b1
    } rx_state_t;

endpackage

// File: rtl/io_port_if.sv
// io_port_if: external TX/RX stream channels of io_port.
//   tx_data/tx_valid : io_port -> sink, FIFO head and not-empty
//   tx_ready         : sink -> io_port, head accepted this cycle
//   rx_data/rx_valid : source -> io_port, word offered
//   rx_ready         : io_port -> source, holding register empty
// master = external peer, slave = io_port.
interface io_port_if
    import io_port_pkg::*;
#(
    parameter int WIDTH = IO_WIDTH
);

    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ready;

    modport master (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid
    );

    modport slave (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid
    );

endinterface

// File: rtl/io_fifo.sv
// io_fifo: first-word fall-through FIFO used on the io_port TX path.
//   clk_i, rst_i : clock, synchronous active-high reset
//   push_i       : write wdata_i (ignored when full unless popping too)
//   pop_i        : advance head (ignored when empty)
//   wdata_i      : write data
//   rdata_o      : head word, 0 while empty
//   count_o      : stored entries, 0..DEPTH
//   full_o       : count_o == DEPTH
//   empty_o      : count_o == 0
module io_fifo
    import io_port_pkg::*;
#(
    parameter int WIDTH = IO_WIDTH,
    parameter int DEPTH = IO_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign count_o = count_q;
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

    // A push into a full FIFO is only taken when the head leaves in the
    // same cycle; popping requires the word to already be visible.
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) wptr_d = wptr_q + 1'b1;
        if (pop_ok)  rptr_d = rptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the read port is masked while empty.
    always_ff @(posedge clk_i) begin
        if (push_ok && !rst_i) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/io_port.sv
// io_port: CPU OUT/INP port bridge to external TX/RX streams.
//   clk_i, rst_i : clock, synchronous active-high reset
//   out_stb_i    : CPU OUT strobe, writes aob_i into the TX FIFO
//   aob_i        : CPU accumulator output bus
//   inp_stb_i    : CPU INP strobe, consumes the RX holding word
//   aib_o        : RX holding word, 0 while empty
//   err_clr_i    : clears ovf_o/udf_o (a same-cycle set wins)
//   tx_full_o    : TX FIFO full
//   ovf_o        : sticky, an OUT write was dropped
//   udf_o        : sticky, an INP read hit an empty register
//   ext          : external TX/RX stream channels
//
// RX holding-register FSM:
//   state   | meaning
//   R_EMPTY | no word held, rx_ready asserted, aib_o = 0
//   R_FULL  | word held on aib_o until an INP strobe consumes it
module io_port
    import io_port_pkg::*;
#(
    parameter int WIDTH = IO_WIDTH,
    parameter int DEPTH = IO_DEPTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             out_stb_i,
    input  logic [WIDTH-1:0] aob_i,
    input  logic             inp_stb_i,
    output logic [WIDTH-1:0] aib_o,
    input  logic             err_clr_i,
    output logic             tx_full_o,
    output logic             ovf_o,
    output logic             udf_o,
    io_port_if.slave         ext
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic            fifo_empty;
    logic            fifo_full;
    logic [CW-1:0]   fifo_count;
    logic            tx_pop;

    rx_state_t        state_q, state_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    assign ext.tx_valid = ~fifo_empty;
    assign tx_pop       = ~fifo_empty & ext.tx_ready;
    assign tx_full_o    = fifo_full;

    io_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (out_stb_i),
        .pop_i   (tx_pop),
        .wdata_i (aob_i),
        .rdata_o (ext.tx_data),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign ext.rx_ready = (state_q == R_EMPTY);
    assign aib_o        = (state_q == R_FULL) ? rx_data_q : '0;
    assign ovf_o        = ovf_q;
    assign udf_o        = udf_q;

    always_comb begin
        state_d   = state_q;
        rx_data_d = rx_data_q;
        ovf_d     = ovf_q;
        udf_d     = udf_q;

        case (state_q)
            R_EMPTY: begin
                if (ext.rx_valid) begin
                    state_d   = R_FULL;
                    rx_data_d = ext.rx_data;
                end
            end
            R_FULL: begin
                if (inp_stb_i) state_d = R_EMPTY;
            end
            default: state_d = R_EMPTY;
        endcase

        if (err_clr_i) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        // Set events take priority over a same-cycle clear.
        if (out_stb_i && (fifo_count == FULL_CNT) && !tx_pop) ovf_d = 1'b1;
        if (inp_stb_i && (state_q == R_EMPTY))                udf_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= R_EMPTY;
            rx_data_q <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_data_q <= rx_data_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

endmodule

// File: tb/tb_io_port.sv
module tb_io_port;
    import io_port_pkg::*;

    localparam int W = 8;
    localparam int D = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, out_stb, inp_stb, err_clr;
    logic [W-1:0] aob, aib;
    logic         tx_full, ovf, udf;

    io_port_if #(.WIDTH(W)) ext();

    io_port #(.WIDTH(W), .DEPTH(D)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .out_stb_i (out_stb),
        .aob_i     (aob),
        .inp_stb_i (inp_stb),
        .aib_o     (aib),
        .err_clr_i (err_clr),
        .tx_full_o (tx_full),
        .ovf_o     (ovf),
        .udf_o     (udf),
        .ext       (ext)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue for the TX FIFO, a held/not-held flag for RX.
    logic [W-1:0] mq[$];
    bit           m_rx_full;
    logic [W-1:0] m_rx_val;
    bit           m_ovf, m_udf, m_live;

    // Inputs change just after each rising edge, so at the falling edge the
    // DUT shows the state from the last edge and the inputs are those the
    // next edge will sample.
    initial begin
        m_live = 0;
        forever begin
            @(negedge clk);
            if (m_live) begin
                chk("tx_valid", 32'(ext.tx_valid), 32'(mq.size() != 0));
                chk("tx_data",  32'(ext.tx_data),  (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
                chk("tx_full",  32'(tx_full),      32'(mq.size() == D));
                chk("count",    32'(dut.u_fifo.count_o), 32'(mq.size()));
                chk("rx_ready", 32'(ext.rx_ready), 32'(!m_rx_full));
                chk("aib",      32'(aib),          m_rx_full ? 32'(m_rx_val) : 32'd0);
                chk("ovf",      32'(ovf),          32'(m_ovf));
                chk("udf",      32'(udf),          32'(m_udf));
            end
            if (rst) begin
                mq.delete();
                m_rx_full = 0;
                m_rx_val  = '0;
                m_ovf     = 0;
                m_udf     = 0;
                m_live    = 1;
            end else if (m_live) begin
                bit pop, room, ovs, uds;
                pop  = (mq.size() != 0) && ext.tx_ready;
                room = (mq.size() < D) || pop;
                ovs  = out_stb && !room;
                uds  = inp_stb && !m_rx_full;
                if (pop) void'(mq.pop_front());
                if (out_stb && room) mq.push_back(aob);
                if (!m_rx_full) begin
                    if (ext.rx_valid) begin
                        m_rx_full = 1;
                        m_rx_val  = ext.rx_data;
                    end
                end else if (inp_stb) begin
                    m_rx_full = 0;
                end
                m_ovf = ovs || (m_ovf && !err_clr);
                m_udf = uds || (m_udf && !err_clr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] v);
        out_stb = 1'b1;
        aob     = v;
        tick();
        out_stb = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; out_stb = 1'b0; inp_stb = 1'b0; err_clr = 1'b0; aob = '0;
        ext.tx_ready = 1'b0; ext.rx_valid = 1'b0; ext.rx_data = '0;
        tick(); tick();
        chk("rst_tx_valid", 32'(ext.tx_valid), 32'd0);
        chk("rst_tx_data",  32'(ext.tx_data),  32'd0);
        chk("rst_rx_ready", 32'(ext.rx_ready), 32'd1);
        chk("rst_aib",      32'(aib),          32'd0);
        rst = 1'b0;

        // Three pushes, then drain in order.
        push(8'h11);
        chk("fwft_first", 32'(ext.tx_data), 32'h11);
        push(8'h22);
        push(8'h33);
        chk("cnt3",       32'(dut.u_fifo.count_o), 32'd3);
        chk("head_11",    32'(ext.tx_data), 32'h11);
        ext.tx_ready = 1'b1;
        tick(); chk("drain_22", 32'(ext.tx_data), 32'h22);
        tick(); chk("drain_33", 32'(ext.tx_data), 32'h33);
        tick(); chk("drained",  32'(ext.tx_valid), 32'd0);

        // Push into empty with the sink ready: word must survive one cycle.
        out_stb = 1'b1; aob = 8'hC5;
        tick(); out_stb = 1'b0;
        chk("empty_push_valid", 32'(ext.tx_valid), 32'd1);
        chk("empty_push_data",  32'(ext.tx_data),  32'hC5);
        tick();
        chk("empty_push_gone",  32'(ext.tx_valid), 32'd0);
        ext.tx_ready = 1'b0;

        // Overflow: fifth word dropped.
        for (int i = 0; i < 5; i++) begin
            push(8'hA0 + 8'(i));
            if (i == 3) begin
                chk("full_after_4", 32'(tx_full), 32'd1);
                chk("no_ovf_yet",   32'(ovf),     32'd0);
            end
        end
        chk("ovf_set", 32'(ovf), 32'd1);
        chk("ovf_cnt", 32'(dut.u_fifo.count_o), 32'd4);
        ext.tx_ready = 1'b1;
        chk("ovf_d0", 32'(ext.tx_data), 32'hA0);
        tick(); chk("ovf_d1", 32'(ext.tx_data), 32'hA1);
        tick(); chk("ovf_d2", 32'(ext.tx_data), 32'hA2);
        tick(); chk("ovf_d3", 32'(ext.tx_data), 32'hA3);
        tick(); chk("ovf_empty", 32'(ext.tx_valid), 32'd0);
        ext.tx_ready = 1'b0;
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("ovf_clr", 32'(ovf), 32'd0);

        // Push and pop together while full.
        for (int i = 0; i < 4; i++) push(8'hB0 + 8'(i));
        out_stb = 1'b1; aob = 8'h55; ext.tx_ready = 1'b1;
        tick(); out_stb = 1'b0;
        chk("pp_no_ovf", 32'(ovf), 32'd0);
        chk("pp_cnt4",   32'(dut.u_fifo.count_o), 32'd4);
        chk("pp_head",   32'(ext.tx_data), 32'hB1);
        tick(); tick(); tick();
        chk("pp_last_55", 32'(ext.tx_data), 32'h55);
        tick();
        chk("pp_empty", 32'(ext.tx_valid), 32'd0);
        ext.tx_ready = 1'b0;

        // RX capture and consume.
        ext.rx_valid = 1'b1; ext.rx_data = 8'h7E;
        tick(); ext.rx_valid = 1'b0;
        chk("rx_busy", 32'(ext.rx_ready), 32'd0);
        chk("rx_aib",  32'(aib), 32'h7E);
        inp_stb = 1'b1;
        chk("rx_hold", 32'(aib), 32'h7E);
        tick(); inp_stb = 1'b0;
        chk("rx_done_aib",   32'(aib), 32'd0);
        chk("rx_done_ready", 32'(ext.rx_ready), 32'd1);

        // Source and CPU both streaming: one word per two cycles.
        ext.rx_valid = 1'b1; inp_stb = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ext.rx_data = 8'h40 + 8'(i);
            tick();
        end
        ext.rx_valid = 1'b0; inp_stb = 1'b0;
        err_clr = 1'b1; tick(); err_clr = 1'b0;

        // Underflow and clear priority.
        inp_stb = 1'b1; tick(); inp_stb = 1'b0;
        chk("udf_set", 32'(udf), 32'd1);
        chk("udf_aib", 32'(aib), 32'd0);
        err_clr = 1'b1; tick();
        chk("udf_clr", 32'(udf), 32'd0);
        inp_stb = 1'b1; tick(); inp_stb = 1'b0; err_clr = 1'b0;
        chk("udf_set_wins", 32'(udf), 32'd1);

        // Reset mid-transfer with every strobe asserted.
        push(8'h01); push(8'h02); push(8'h03);
        ext.rx_valid = 1'b1; ext.rx_data = 8'h9A;
        tick(); ext.rx_valid = 1'b0;
        chk("pre_rst_rx", 32'(ext.rx_ready), 32'd0);
        rst = 1'b1; out_stb = 1'b1; aob = 8'hFF; inp_stb = 1'b1;
        ext.rx_valid = 1'b1; ext.tx_ready = 1'b1;
        tick();
        rst = 1'b0; out_stb = 1'b0; inp_stb = 1'b0; ext.rx_valid = 1'b0; ext.tx_ready = 1'b0;
        chk("r_tx_valid", 32'(ext.tx_valid), 32'd0);
        chk("r_tx_full",  32'(tx_full), 32'd0);
        chk("r_tx_data",  32'(ext.tx_data), 32'd0);
        chk("r_cnt",      32'(dut.u_fifo.count_o), 32'd0);
        chk("r_rx_ready", 32'(ext.rx_ready), 32'd1);
        chk("r_aib",      32'(aib), 32'd0);
        chk("r_ovf",      32'(ovf), 32'd0);
        chk("r_udf",      32'(udf), 32'd0);
        tick(); tick();
        chk("r_still_empty", 32'(ext.tx_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
